// File: rtl/bit_serializer_pkg.sv
// bit_serializer_pkg
// Shared definitions for the bit serializer slice: FSM state encoding,
// default word width and the frame-length derivation.
//
// Build option: BIT_SERIALIZER_PARITY_EN appends one even-parity bit to every
// frame (FRAME_LEN = WIDTH + 1); left undefined, frames are WIDTH bits long.

`ifdef BIT_SERIALIZER_PARITY_EN
`define BIT_SERIALIZER_FRAME_LEN(w) ((w) + 1)
`else
`define BIT_SERIALIZER_FRAME_LEN(w) (w)
`endif

package bit_serializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    function automatic int frame_len(input int width);
        return `BIT_SERIALIZER_FRAME_LEN(width);
    endfunction

endpackage

// File: rtl/bit_serializer_if.sv
// bit_serializer_if
// Word-in / bit-out bundle of the serializer.
//   din, din_valid, din_ready : parallel word handshake (master -> slave)
//   x, x_valid                : serial bit stream to the sequence detector
//   busy                      : shifter active or holding register occupied
// The serializer itself uses the slave modport; its source uses master.

interface bit_serializer_if
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             x;
    logic             x_valid;
    logic             busy;

    modport master (
        output din, din_valid,
        input  din_ready, x, x_valid, busy
    );

    modport slave (
        input  din, din_valid,
        output din_ready, x, x_valid, busy
    );
endinterface

// File: rtl/bit_serializer_word_hold_reg.sv
// word_hold_reg
// One-word holding register with occupancy flag. Lets the next word be
// accepted while the current one is still being shifted out.
//   clk, rst_n : clock, asynchronous active-low clear
//   load       : capture d and mark full
//   take       : consumer has taken q; mark empty
//   d / q      : word in / stored word
//   full       : q holds a word not yet taken

module word_hold_reg
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             take,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             full
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q    <= '0;
            full <= 1'b0;
        end else if (load) begin
            q    <= d;
            full <= 1'b1;
        end else if (take) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/bit_serializer.sv
// bit_serializer
// Converts parallel words into an MSB-first one-bit-per-clock stream for the
// downstream sequence detector. A holding register lets consecutive words
// stream without an idle cycle between frames.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : bit_serializer_if.slave (din/din_valid/din_ready in,
//                x/x_valid/busy out)
// Build option: BIT_SERIALIZER_PARITY_EN appends an even-parity bit per frame.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | nothing to shift; x = IDLE_BIT, x_valid = 0
// ST_SHIFT | shifter MSB (or parity bit) on x, x_valid = 1

module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int   WIDTH    = DEFAULT_WIDTH,
    parameter logic IDLE_BIT = 1'b0
) (
    input logic             clk,
    input logic             rst_n,
    bit_serializer_if.slave bus
);

    localparam int             FRAME_LEN = frame_len(WIDTH);
    localparam int             CW        = $clog2(WIDTH + 2);
    localparam logic [CW-1:0]  LAST_CNT  = CW'(FRAME_LEN - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hold_q;
    logic             hold_full;
    logic             accept;
    logic             last_bit;
    logic             load_shreg;
    logic             hold_load;
    logic             hold_take;
    logic [WIDTH-1:0] load_word;

    // Ready depends only on registered occupancy, never on din_valid.
    assign bus.din_ready = !hold_full;
    assign accept        = bus.din_valid && !hold_full;
    assign last_bit      = (state == ST_SHIFT) && (cnt == LAST_CNT);

    word_hold_reg #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk  (clk),
        .rst_n(rst_n),
        .load (hold_load),
        .take (hold_take),
        .d    (bus.din),
        .q    (hold_q),
        .full (hold_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        load_shreg = 1'b0;
        hold_load  = 1'b0;
        hold_take  = 1'b0;
        load_word  = bus.din;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    load_shreg = 1'b1;
                    state_nxt  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (last_bit) begin
                    // Held word goes first; otherwise a word arriving on the
                    // last bit bypasses the hold straight into the shifter.
                    if (hold_full) begin
                        load_shreg = 1'b1;
                        hold_take  = 1'b1;
                        load_word  = hold_q;
                    end else if (accept) begin
                        load_shreg = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else if (accept) begin
                    hold_load = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (load_shreg) begin
            shreg <= load_word;
            cnt   <= '0;
        end else if (state == ST_SHIFT) begin
            shreg <= {shreg[WIDTH-2:0], 1'b0};
            cnt   <= cnt + CW'(1);
        end
    end

`ifdef BIT_SERIALIZER_PARITY_EN
    // Parity is latched with the word so the source may change din freely.
    logic parity;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity <= 1'b0;
        end else if (load_shreg) begin
            parity <= ^load_word;
        end
    end
`endif

    always_comb begin
        bus.x       = IDLE_BIT;
        bus.x_valid = 1'b0;
        bus.busy    = (state == ST_SHIFT) || hold_full;
        if (state == ST_SHIFT) begin
            bus.x_valid = 1'b1;
`ifdef BIT_SERIALIZER_PARITY_EN
            bus.x       = (cnt == LAST_CNT) ? parity : shreg[WIDTH-1];
`else
            bus.x       = shreg[WIDTH-1];
`endif
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer
// Self-checking bench for bit_serializer. The reference model tracks each
// accepted word and the cycle its frame starts: a frame starts on the cycle
// after acceptance or right after the previous frame ends, whichever is
// later. Line outputs, ready and busy are derived from that schedule.

module tb_bit_serializer;

    localparam int   WIDTH    = 8;
    localparam logic IDLE_BIT = 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
    localparam int   FL       = WIDTH + 1;
`else
    localparam int   FL       = WIDTH;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc     = 0;

    logic [WIDTH-1:0] mw[$];
    int               ms[$];

    bit_serializer_if #(.WIDTH(WIDTH)) bus ();

    bit_serializer #(
        .WIDTH   (WIDTH),
        .IDLE_BIT(IDLE_BIT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic m_bit(input logic [WIDTH-1:0] w, input int k);
        if (k < WIDTH) return w[WIDTH-1-k];
        return ^w;
    endfunction

    function automatic int m_slot(input int c);
        foreach (ms[i]) if (c >= ms[i] && c < ms[i] + FL) return i;
        return -1;
    endfunction

    function automatic logic m_ready(input int c);
        foreach (ms[i]) if (ms[i] > c) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic m_xv(input int c);
        return m_slot(c) >= 0;
    endfunction

    function automatic logic m_x(input int c);
        int i;
        i = m_slot(c);
        if (i < 0) return IDLE_BIT;
        return m_bit(mw[i], c - ms[i]);
    endfunction

    // Drive one cycle (called at a falling edge, returns at the next one).
    task automatic step(input logic v, input logic [WIDTH-1:0] d, output bit acc);
        int s;
        bus.din_valid = v;
        bus.din       = d;
        acc = v && m_ready(cyc);
        @(posedge clk);
        cyc++;
        if (acc) begin
            s = cyc;
            if (ms.size() > 0 && ms[$] + FL > s) s = ms[$] + FL;
            mw.push_back(d);
            ms.push_back(s);
        end
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bus.din_valid = 1'b0;
        bus.din       = '0;
        rst_n         = 1'b0;
        #1;
        n_total += 4;
        if (bus.x !== IDLE_BIT) $display("FAIL reset_x got %b want %b", bus.x, IDLE_BIT); else n_pass++;
        if (bus.x_valid !== 1'b0) $display("FAIL reset_xv got %b want 0", bus.x_valid); else n_pass++;
        if (bus.din_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", bus.din_ready); else n_pass++;
        if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [WIDTH-1:0] pat;
        logic             eb;
        bit               acc;
        pat = 8'hA5;
        step(1'b1, pat, acc);
        for (int k = 0; k < FL; k++) begin
            eb = (k < WIDTH) ? pat[WIDTH-1-k] : 1'b0;
            n_total += 2;
            if (bus.x !== eb) $display("FAIL single_x bit %0d got %b want %b", k, bus.x, eb); else n_pass++;
            if (bus.x_valid !== 1'b1) $display("FAIL single_xv bit %0d got %b want 1", k, bus.x_valid); else n_pass++;
            step(1'b0, WIDTH'($urandom), acc);
        end
        n_total += 2;
        if (bus.x !== IDLE_BIT) $display("FAIL single_idle_x got %b want %b", bus.x, IDLE_BIT); else n_pass++;
        if (bus.x_valid !== 1'b0) $display("FAIL single_idle_xv got %b want 0", bus.x_valid); else n_pass++;
        repeat (2) step(1'b0, '0, acc);
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] w0, w1;
        logic             got[$];
        logic             want[$];
        int               first, last;
        bit               acc;
        w0 = 8'hA5;
        w1 = 8'h3C;
        for (int k = 0; k < FL; k++) want.push_back(m_bit(w0, k));
        for (int k = 0; k < FL; k++) want.push_back(m_bit(w1, k));
        first = -1;
        last  = -1;
        for (int t = 0; t < 2 * FL + 4; t++) begin
            step(t < 2, (t == 0) ? w0 : w1, acc);
            if (bus.x_valid === 1'b1) begin
                if (first < 0) first = t;
                last = t;
                got.push_back(bus.x);
            end
        end
        bus.din_valid = 1'b0;
        n_total += 2;
        if (got.size() != 2 * FL) $display("FAIL b2b_count got %0d want %0d", got.size(), 2 * FL); else n_pass++;
        if (last - first + 1 != 2 * FL) $display("FAIL b2b_gap span got %0d want %0d", last - first + 1, 2 * FL); else n_pass++;
        for (int k = 0; k < 2 * FL && k < got.size(); k++) begin
            n_total++;
            if (got[k] !== want[k]) $display("FAIL b2b_bit %0d got %b want %b", k, got[k], want[k]); else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] w[3];
        logic             got[$];
        logic             ex;
        bit               acc;
        int               tries;
        for (int i = 0; i < 3; i++) w[i] = WIDTH'($urandom);
        for (int i = 0; i < 3; i++) begin
            tries = 0;
            do begin
                step(1'b1, w[i], acc);
                tries++;
                ex = m_x(cyc);
                n_total += 3;
                if (bus.x !== ex) $display("FAIL bp_x cyc %0d got %b want %b", cyc, bus.x, ex); else n_pass++;
                if (bus.x_valid !== m_xv(cyc)) $display("FAIL bp_xv cyc %0d got %b want %b", cyc, bus.x_valid, m_xv(cyc)); else n_pass++;
                if (bus.din_ready !== m_ready(cyc)) $display("FAIL bp_ready cyc %0d got %b want %b", cyc, bus.din_ready, m_ready(cyc)); else n_pass++;
                if (acc && i == 1) begin
                    n_total++;
                    if (bus.din_ready !== 1'b0) $display("FAIL bp_ready_drop got %b want 0", bus.din_ready); else n_pass++;
                end
                if (bus.x_valid === 1'b1) got.push_back(bus.x);
            end while (!acc && tries < 4 * FL);
            if (!acc) begin
                n_total++;
                $display("FAIL bp_accept_timeout word %0d got none want accept", i);
            end
        end
        for (int t = 0; t < 3 * FL + 2; t++) begin
            step(1'b0, WIDTH'($urandom), acc);
            n_total++;
            if (bus.din_ready !== m_ready(cyc)) $display("FAIL bp_ready cyc %0d got %b want %b", cyc, bus.din_ready, m_ready(cyc)); else n_pass++;
            if (bus.x_valid === 1'b1) got.push_back(bus.x);
        end
        n_total++;
        if (got.size() != 3 * FL) $display("FAIL bp_count got %0d want %0d", got.size(), 3 * FL); else n_pass++;
        for (int k = 0; k < 3 * FL && k < got.size(); k++) begin
            ex = m_bit(w[k / FL], k % FL);
            n_total++;
            if (got[k] !== ex) $display("FAIL bp_bit %0d got %b want %b", k, got[k], ex); else n_pass++;
        end
    endtask

    task automatic test_bypass();
        bit   acc;
        logic ex;
        step(1'b1, 8'hF0, acc);
        for (int t = 0; t < 2 * FL; t++) begin
            ex = m_x(cyc);
            n_total += 4;
            if (bus.x !== ex) $display("FAIL bypass_x cyc %0d got %b want %b", cyc, bus.x, ex); else n_pass++;
            if (bus.x_valid !== 1'b1) $display("FAIL bypass_xv cyc %0d got %b want 1", cyc, bus.x_valid); else n_pass++;
            if (bus.busy !== 1'b1) $display("FAIL bypass_busy cyc %0d got %b want 1", cyc, bus.busy); else n_pass++;
            if (bus.din_ready !== 1'b1) $display("FAIL bypass_ready cyc %0d got %b want 1", cyc, bus.din_ready); else n_pass++;
            // Second word offered only while the first word's last bit is on x.
            step(t == FL - 1, (t == FL - 1) ? 8'h0F : WIDTH'($urandom), acc);
        end
        n_total += 2;
        if (bus.x_valid !== 1'b0) $display("FAIL bypass_end_xv got %b want 0", bus.x_valid); else n_pass++;
        if (bus.busy !== 1'b0) $display("FAIL bypass_end_busy got %b want 0", bus.busy); else n_pass++;
    endtask

    task automatic test_async_reset();
        bit acc;
        step(1'b1, 8'hFF, acc);
        step(1'b0, '0, acc);
        step(1'b0, '0, acc);
        #2;
        rst_n = 1'b0;
        #1;
        n_total += 4;
        if (bus.x !== IDLE_BIT) $display("FAIL arst_x got %b want %b", bus.x, IDLE_BIT); else n_pass++;
        if (bus.x_valid !== 1'b0) $display("FAIL arst_xv got %b want 0", bus.x_valid); else n_pass++;
        if (bus.din_ready !== 1'b1) $display("FAIL arst_ready got %b want 1", bus.din_ready); else n_pass++;
        if (bus.busy !== 1'b0) $display("FAIL arst_busy got %b want 0", bus.busy); else n_pass++;
        mw.delete();
        ms.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < FL + 2; t++) begin
            step(1'b0, WIDTH'($urandom), acc);
            n_total += 2;
            if (bus.x_valid !== 1'b0) $display("FAIL arst_residual_xv cyc %0d got %b want 0", cyc, bus.x_valid); else n_pass++;
            if (bus.x !== IDLE_BIT) $display("FAIL arst_residual_x cyc %0d got %b want %b", cyc, bus.x, IDLE_BIT); else n_pass++;
        end
    endtask

`ifdef BIT_SERIALIZER_PARITY_EN
    task automatic test_parity();
        logic [WIDTH-1:0] w[2];
        logic             par[2];
        bit               acc;
        int               nv;
        w[0] = 8'hA5; par[0] = 1'b0;
        w[1] = 8'h07; par[1] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, w[i], acc);
            nv = 0;
            for (int t = 0; t < FL + 2; t++) begin
                if (bus.x_valid === 1'b1) nv++;
                if (t == FL - 1) begin
                    n_total++;
                    if (bus.x !== par[i]) $display("FAIL parity_bit word %0d got %b want %b", i, bus.x, par[i]); else n_pass++;
                end
                step(1'b0, WIDTH'($urandom), acc);
            end
            n_total++;
            if (nv != 9) $display("FAIL parity_len word %0d got %0d want 9", i, nv); else n_pass++;
        end
    endtask
`endif

    task automatic test_random();
        bit               acc;
        logic             v;
        logic             ex;
        for (int t = 0; t < 400; t++) begin
            v = ($urandom_range(0, 2) != 0);
            step(v, WIDTH'($urandom), acc);
            ex = m_x(cyc);
            n_total += 4;
            if (bus.x !== ex) $display("FAIL rand_x cyc %0d got %b want %b", cyc, bus.x, ex); else n_pass++;
            if (bus.x_valid !== m_xv(cyc)) $display("FAIL rand_xv cyc %0d got %b want %b", cyc, bus.x_valid, m_xv(cyc)); else n_pass++;
            if (bus.din_ready !== m_ready(cyc)) $display("FAIL rand_ready cyc %0d got %b want %b", cyc, bus.din_ready, m_ready(cyc)); else n_pass++;
            if (bus.busy !== (m_xv(cyc) || !m_ready(cyc))) $display("FAIL rand_busy cyc %0d got %b want %b", cyc, bus.busy, m_xv(cyc) || !m_ready(cyc)); else n_pass++;
        end
        bus.din_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_bypass();
        test_async_reset();
`ifdef BIT_SERIALIZER_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
